// File: rtl/load_buffer_pkg.sv
// Shared types for the load buffer: the packet and CDB formats, the controller states
// and the funct3 load-size encodings.
package load_buffer_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned ROB_TAG_W = 5;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      address;
    logic [ROB_TAG_W-1:0] rd_tag;
    logic [2:0]           mem_size;
  } LB_PACKET;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      value;
    logic [ROB_TAG_W-1:0] rob_tag;
  } CDB_DATA;

  typedef struct packed {
    logic [XLEN-1:0]      address;
    logic [ROB_TAG_W-1:0] rd_tag;
    logic [2:0]           mem_size;
  } LB_ENTRY;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_RESP,
    BCAST,
    DRAIN
  } LB_STATE;

  localparam logic [2:0] MEM_LB  = 3'b000;
  localparam logic [2:0] MEM_LH  = 3'b001;
  localparam logic [2:0] MEM_LW  = 3'b010;
  localparam logic [2:0] MEM_LBU = 3'b100;
  localparam logic [2:0] MEM_LHU = 3'b101;

endpackage

// File: rtl/load_data_align.sv
// Extracts and sign/zero-extends the loaded byte, halfword or word from a memory word.
// Purely combinational; shared with the store-to-load forwarding path.
module load_data_align
  import load_buffer_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    // Halfwords only honour offset[1]; misalignment is not checked.
    half_sel = word[{offset[1], 4'b0000} +: 16];
    case (funct3)
      MEM_LB:  result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      MEM_LBU: result = {{(XLEN-8){1'b0}}, byte_sel};
      MEM_LH:  result = {{(XLEN-16){half_sel[15]}}, half_sel};
      MEM_LHU: result = {{(XLEN-16){1'b0}}, half_sel};
      MEM_LW:  result = word;
      default: result = XLEN'(32'hdeadbeef);
    endcase
  end

endmodule

// File: rtl/load_buffer.sv
// In-order load queue: issues one memory read at a time, aligns the returned word and
// broadcasts it on the CDB until granted. Squashed entirely on flush.
module load_buffer
  import load_buffer_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter bit          OVERFLOW_CHECK = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  LB_PACKET        lb_packet_in,
  output logic            lb_full,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output CDB_DATA         lb_cdb_output,
  input  logic            cdb_grant
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  LB_ENTRY         entries_q [DEPTH];
  LB_ENTRY         head_entry;
  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q, count_d;
  logic            full_q;
  LB_STATE         state_q, state_d;
  logic [XLEN-1:0] result_q, aligned;
  logic            enq, pop, overflow;

  assign head_entry = entries_q[head_q];
  assign enq        = lb_packet_in.valid && !full_q && !flush;
  assign overflow   = lb_packet_in.valid && full_q;
  assign pop        = (state_q == BCAST) && cdb_grant && !flush;
  assign count_d    = flush ? '0 : count_q + CntW'(enq) - CntW'(pop);

  load_data_align u_align (
    .word   (mem_resp_data),
    .offset (head_entry.address[1:0]),
    .funct3 (head_entry.mem_size),
    .result (aligned)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      // An arriving packet starts the request immediately to save a cycle.
      IDLE:      if (!flush && (count_q != '0 || enq)) state_d = REQ;
      REQ: begin
        if (flush)              state_d = mem_req_ready ? DRAIN : IDLE;
        else if (mem_req_ready) state_d = WAIT_RESP;
      end
      WAIT_RESP: begin
        // A response landing on the flush cycle is consumed here, so nothing is left to drain.
        if (mem_resp_valid) state_d = flush ? IDLE : BCAST;
        else if (flush)     state_d = DRAIN;
      end
      BCAST:     if (flush || cdb_grant) state_d = IDLE;
      DRAIN:     if (mem_resp_valid) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      state_q  <= IDLE;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      full_q  <= (count_d == CntW'(DEPTH));
      if (flush) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (enq) begin
          entries_q[tail_q] <= '{address:  lb_packet_in.address,
                                 rd_tag:   lb_packet_in.rd_tag,
                                 mem_size: lb_packet_in.mem_size};
          tail_q <= tail_q + 1'b1;
        end
        if (pop) head_q <= head_q + 1'b1;
      end
      if (state_q == WAIT_RESP && mem_resp_valid) result_q <= aligned;
    end
  end

  always_comb begin
    lb_full       = full_q;
    mem_req_valid = (state_q == REQ);
    mem_req_addr  = {head_entry.address[XLEN-1:2], 2'b00};
    lb_cdb_output = '0;
    if (state_q == BCAST) begin
      lb_cdb_output.valid   = 1'b1;
      lb_cdb_output.value   = result_q;
      lb_cdb_output.rob_tag = head_entry.rd_tag;
    end
  end

  if (OVERFLOW_CHECK) begin : g_overflow_check
    lb_overflow: assert property (@(posedge clock) disable iff (!reset) !overflow)
      else $error("lb_overflow: load packet dropped while buffer full");
  end

endmodule

// File: tb/tb_load_buffer.sv
// Directed bench for load_buffer: latency, alignment, fill/overflow, CDB backpressure,
// flush/drain, pointer wrap and asynchronous reset.
module tb_load_buffer;
  import load_buffer_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  LB_PACKET    pkt;
  logic        lb_full;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  CDB_DATA     cdb;
  logic        cdb_grant;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  load_buffer #(
    .DEPTH          (4),
    .OVERFLOW_CHECK (1'b0)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .lb_packet_in   (pkt),
    .lb_full        (lb_full),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .lb_cdb_output  (cdb),
    .cdb_grant      (cdb_grant)
  );

  task automatic drive(input logic [31:0] addr, input logic [4:0] tag, input logic [2:0] f3);
    pkt = '{valid: 1'b1, address: addr, rd_tag: tag, mem_size: f3};
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; pkt = '0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = '0; cdb_grant = 1'b0;
    #3;
    checks++;
    if ({mem_req_valid, mem_req_addr, cdb, lb_full} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h, expected 0",
                         {mem_req_valid, mem_req_addr, cdb, lb_full});
    end
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (dut.state_q !== IDLE) begin
      errors++; $display("FAIL reset_state: got %0d, expected %0d", dut.state_q, IDLE);
    end
    checks++;
    if (dut.count_q !== 3'd0) begin
      errors++; $display("FAIL reset_count: got %0d, expected 0", dut.count_q);
    end
    checks++;
    if (mem_req_valid !== 1'b0 || cdb.valid !== 1'b0) begin
      errors++; $display("FAIL reset_idle_out: got req=%b cdb=%b, expected 0 0",
                         mem_req_valid, cdb.valid);
    end
  endtask

  // Exact-latency single load: packet cycle 0, request 1, response 2, CDB 3.
  task automatic test_single(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] tag,
                             input logic [31:0] req_addr, input logic [31:0] exp);
    @(negedge clock);
    drive(addr, tag, f3); mem_req_ready = 1'b1;
    @(negedge clock);
    pkt.valid = 1'b0;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== req_addr) begin
      errors++; $display("FAIL single_req: got %b/%h, expected 1/%h",
                         mem_req_valid, mem_req_addr, req_addr);
    end
    @(negedge clock);
    checks++;
    if (mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL single_req_drop: got %b, expected 0", mem_req_valid);
    end
    mem_resp_valid = 1'b1; mem_resp_data = 32'h80FF_1234;
    @(negedge clock);
    mem_resp_valid = 1'b0;
    checks++;
    if (cdb.valid !== 1'b1 || cdb.value !== exp || cdb.rob_tag !== tag) begin
      errors++; $display("FAIL single_cdb f3=%b: got %b/%h/%0d, expected 1/%h/%0d",
                         f3, cdb.valid, cdb.value, cdb.rob_tag, exp, tag);
    end
    cdb_grant = 1'b1;
    @(negedge clock);
    cdb_grant = 1'b0; mem_req_ready = 1'b0;
    checks++;
    if (cdb.valid !== 1'b0 || dut.count_q !== 3'd0) begin
      errors++; $display("FAIL single_pop: got cdb=%b count=%0d, expected 0 0",
                         cdb.valid, dut.count_q);
    end
  endtask

  // Serves whatever request is pending with a one-cycle response and an immediate grant.
  task automatic serve(input logic [4:0] tag, input logic [31:0] addr, input logic [31:0] data);
    int n = 0;
    while (mem_req_valid !== 1'b1 && n < 20) begin
      @(negedge clock); n++;
    end
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== addr) begin
      errors++; $display("FAIL serve_req tag %0d: got %b/%h, expected 1/%h",
                         tag, mem_req_valid, mem_req_addr, addr);
    end
    mem_req_ready = 1'b1;
    @(negedge clock);
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = data;
    @(negedge clock);
    mem_resp_valid = 1'b0;
    checks++;
    if (cdb.valid !== 1'b1 || cdb.value !== data || cdb.rob_tag !== tag) begin
      errors++; $display("FAIL serve_cdb: got %b/%h/%0d, expected 1/%h/%0d",
                         cdb.valid, cdb.value, cdb.rob_tag, data, tag);
    end
    cdb_grant = 1'b1;
    @(negedge clock);
    cdb_grant = 1'b0;
  endtask

  task automatic test_fill();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (lb_full !== 1'b0) begin
        errors++; $display("FAIL fill_early_full at %0d: got %b, expected 0", i, lb_full);
      end
      drive(32'h100 + 32'(4 * i), 5'(i + 1), MEM_LW);
    end
    @(negedge clock);
    checks++;
    if (lb_full !== 1'b1 || dut.count_q !== 3'd4) begin
      errors++; $display("FAIL fill_full: got %b/%0d, expected 1/4", lb_full, dut.count_q);
    end
    drive(32'h1F0, 5'd9, MEM_LW);
    #1;
    checks++;
    if (dut.overflow !== 1'b1) begin
      errors++; $display("FAIL fill_overflow_flag: got %b, expected 1", dut.overflow);
    end
    @(negedge clock);
    pkt.valid = 1'b0;
    checks++;
    if (lb_full !== 1'b1 || dut.count_q !== 3'd4) begin
      errors++; $display("FAIL fill_drop: got %b/%0d, expected 1/4", lb_full, dut.count_q);
    end
    for (int t = 1; t <= 4; t++)
      serve(5'(t), 32'h100 + 32'(4 * (t - 1)), 32'hA000_0000 + 32'(t));
    checks++;
    if (lb_full !== 1'b0 || dut.count_q !== 3'd0) begin
      errors++; $display("FAIL fill_empty: got %b/%0d, expected 0/0", lb_full, dut.count_q);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clock);
    drive(32'h200, 5'd7, MEM_LW); mem_req_ready = 1'b1;
    @(negedge clock);
    pkt.valid = 1'b0;
    @(negedge clock);
    mem_resp_valid = 1'b1; mem_resp_data = 32'h1122_3344;
    @(negedge clock);
    mem_resp_valid = 1'b0;
    drive(32'h204, 5'd8, MEM_LW);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      pkt.valid = 1'b0;
      checks++;
      if (cdb.valid !== 1'b1 || cdb.value !== 32'h1122_3344 || cdb.rob_tag !== 5'd7
          || mem_req_valid !== 1'b0) begin
        errors++; $display("FAIL bp_hold %0d: got %b/%h/%0d req=%b, expected 1/11223344/7 req=0",
                           c, cdb.valid, cdb.value, cdb.rob_tag, mem_req_valid);
      end
    end
    cdb_grant = 1'b1;
    @(negedge clock);
    cdb_grant = 1'b0;
    checks++;
    if (cdb.valid !== 1'b0 || mem_req_valid !== 1'b0 || dut.count_q !== 3'd1) begin
      errors++; $display("FAIL bp_pop: got cdb=%b req=%b count=%0d, expected 0 0 1",
                         cdb.valid, mem_req_valid, dut.count_q);
    end
    @(negedge clock);
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h204) begin
      errors++; $display("FAIL bp_next_req: got %b/%h, expected 1/204",
                         mem_req_valid, mem_req_addr);
    end
    serve(5'd8, 32'h204, 32'h5566_7788);
  endtask

  task automatic test_flush();
    @(negedge clock);
    drive(32'h300, 5'd2, MEM_LW); mem_req_ready = 1'b1;
    @(negedge clock);
    drive(32'h304, 5'd3, MEM_LW);
    @(negedge clock);
    pkt.valid = 1'b0; mem_req_ready = 1'b0;
    checks++;
    if (dut.state_q !== WAIT_RESP || dut.count_q !== 3'd2) begin
      errors++; $display("FAIL flush_pre: got state %0d count %0d, expected %0d 2",
                         dut.state_q, dut.count_q, WAIT_RESP);
    end
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    checks++;
    if (dut.state_q !== DRAIN || dut.count_q !== 3'd0 || mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL flush_drain: got state %0d count %0d req %b, expected %0d 0 0",
                         dut.state_q, dut.count_q, mem_req_valid, DRAIN);
    end
    mem_resp_valid = 1'b1; mem_resp_data = 32'hBAD0_BAD0;
    @(negedge clock);
    mem_resp_valid = 1'b0;
    checks++;
    if (cdb.valid !== 1'b0 || dut.state_q !== IDLE) begin
      errors++; $display("FAIL flush_late_resp: got cdb %b state %0d, expected 0 %0d",
                         cdb.valid, dut.state_q, IDLE);
    end
    @(negedge clock);
    checks++;
    if (cdb.valid !== 1'b0) begin
      errors++; $display("FAIL flush_no_cdb: got %b, expected 0", cdb.valid);
    end
    drive(32'h400, 5'd12, MEM_LW);
    @(negedge clock);
    pkt.valid = 1'b0;
    serve(5'd12, 32'h400, 32'hCAFE_F00D);
  endtask

  task automatic test_wrap();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      drive(32'h500 + 32'(4 * i), 5'(i + 1), MEM_LW);
    end
    @(negedge clock);
    pkt.valid = 1'b0;
    serve(5'd1, 32'h500, 32'h0000_0501);
    @(negedge clock);
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h504) begin
      errors++; $display("FAIL wrap_req: got %b/%h, expected 1/504", mem_req_valid, mem_req_addr);
    end
    mem_req_ready = 1'b1;
    @(negedge clock);
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0502;
    @(negedge clock);
    mem_resp_valid = 1'b0;
    checks++;
    if (cdb.valid !== 1'b1 || cdb.rob_tag !== 5'd2 || dut.count_q !== 3'd2) begin
      errors++; $display("FAIL wrap_bcast: got %b/%0d count %0d, expected 1/2 count 2",
                         cdb.valid, cdb.rob_tag, dut.count_q);
    end
    cdb_grant = 1'b1;
    drive(32'h50C, 5'd4, MEM_LW);
    @(negedge clock);
    cdb_grant = 1'b0; pkt.valid = 1'b0;
    checks++;
    if (dut.count_q !== 3'd2 || dut.tail_q !== 2'd0 || dut.head_q !== 2'd2) begin
      errors++; $display("FAIL wrap_ptrs: got count %0d tail %0d head %0d, expected 2 0 2",
                         dut.count_q, dut.tail_q, dut.head_q);
    end
    serve(5'd3, 32'h508, 32'h0000_0503);
    serve(5'd4, 32'h50C, 32'h0000_0504);
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    drive(32'h600, 5'd3, MEM_LW); mem_req_ready = 1'b0;
    @(negedge clock);
    pkt.valid = 1'b0;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h600) begin
      errors++; $display("FAIL areset_pre: got %b/%h, expected 1/600", mem_req_valid, mem_req_addr);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({mem_req_valid, mem_req_addr, cdb, lb_full} !== '0) begin
      errors++; $display("FAIL areset_outputs: got %h, expected 0",
                         {mem_req_valid, mem_req_addr, cdb, lb_full});
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (dut.state_q !== IDLE || dut.count_q !== 3'd0 || mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL areset_after: got state %0d count %0d req %b, expected %0d 0 0",
                         dut.state_q, dut.count_q, mem_req_valid, IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_single(32'h1003, MEM_LB,  5'd5,  32'h1000, 32'hFFFF_FF80);
    test_single(32'h1003, MEM_LBU, 5'd5,  32'h1000, 32'h0000_0080);
    test_single(32'h1002, MEM_LH,  5'd6,  32'h1000, 32'hFFFF_80FF);
    test_single(32'h1002, MEM_LHU, 5'd7,  32'h1000, 32'h0000_80FF);
    test_single(32'h1001, MEM_LB,  5'd8,  32'h1000, 32'h0000_0012);
    test_single(32'h1000, MEM_LH,  5'd9,  32'h1000, 32'h0000_1234);
    test_single(32'h1000, MEM_LW,  5'd10, 32'h1000, 32'h80FF_1234);
    test_single(32'h1004, 3'b011,  5'd11, 32'h1004, 32'hDEAD_BEEF);
    test_single(32'h1002, MEM_LW,  5'd13, 32'h1000, 32'h80FF_1234);
    test_fill();
    test_backpressure();
    test_flush();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
